// File: rtl/ex_mem_req_pkg.sv
// rtl/ex_mem_req_pkg.sv - shared constants and types for the EX-stage data-SRAM issuer
package ex_mem_req_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // dest_flag layout: {sign, byte, half, offset[1:0]}
    localparam int DEST_FLAG_W = 5;
    localparam int DF_SIGN     = 4;
    localparam int DF_BYTE     = 3;
    localparam int DF_HALF     = 2;

    localparam int ES_BUS_INC          = DEST_FLAG_W;
    localparam int MAX_OUTSTANDING_DEF = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ISSUED = 1'b1
    } state_t;

    typedef struct packed {
        logic                   ale;
        logic [3:0]             wstrb;
        logic [31:0]            wdata;
        logic [DEST_FLAG_W-1:0] dest_flag;
    } fmt_t;

endpackage

// File: rtl/ex_mem_req_if.sv
// rtl/ex_mem_req_if.sv - sram-like request/response bus between EX issuer and data SRAM
interface ex_mem_req_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok
    );
endinterface

// File: rtl/ex_mem_req_fmt.sv
// rtl/ex_mem_req_fmt.sv - combinational formatting of a load/store into SRAM request fields
module mem_req_fmt
    import ex_mem_req_pkg::*;
(
    input  logic        valid_i,
    input  logic        mem_en_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic        excp_i,
    input  logic [31:0] vaddr_i,
    input  logic [31:0] st_data_i,
    output fmt_t        fmt_o
);
    logic misalign;

    always_comb begin
        misalign = ((size_i == SZ_HALF) && vaddr_i[0]) ||
                   ((size_i == SZ_WORD) && (vaddr_i[1:0] != 2'b00));

        fmt_o           = '0;
        fmt_o.ale       = valid_i & mem_en_i & ~excp_i & misalign;

        case (size_i)
            SZ_BYTE: fmt_o.wdata = {4{st_data_i[7:0]}};
            SZ_HALF: fmt_o.wdata = {2{st_data_i[15:0]}};
            default: fmt_o.wdata = st_data_i;
        endcase

        if (we_i) begin
            case (size_i)
                SZ_BYTE: fmt_o.wstrb = 4'b0001 << vaddr_i[1:0];
                SZ_HALF: fmt_o.wstrb = 4'b0011 << vaddr_i[1:0];
                default: fmt_o.wstrb = 4'b1111;
            endcase
        end else if ((size_i == SZ_BYTE) || (size_i == SZ_HALF)) begin
            // word loads need no extraction, so they keep the all-zero code
            fmt_o.dest_flag[DF_SIGN] = signed_i;
            fmt_o.dest_flag[DF_BYTE] = (size_i == SZ_BYTE);
            fmt_o.dest_flag[DF_HALF] = (size_i == SZ_HALF);
            fmt_o.dest_flag[1:0]     = vaddr_i[1:0];
        end
    end
endmodule

// File: rtl/ex_mem_req.sv
// rtl/ex_mem_req.sv - EX-stage data-SRAM request issuer with in-flight tracking and flush discard
module ex_mem_req
    import ex_mem_req_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic        ex_mem_en,
    input  logic        ex_mem_we,
    input  logic [1:0]  ex_size,
    input  logic        ex_signed,
    input  logic [31:0] ex_vaddr,
    input  logic [31:0] ex_st_data,
    input  logic        ex_excp_in,
    input  logic        ME_Allow_in,
    input  logic        flush,
    output logic        ex_ready_go,
    output logic        ex_ale,
    output logic [4:0]  ex_dest_flag,
    ex_mem_req_if.master sram,
    output logic        me_data_ok,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_C = MAX_OUTSTANDING[CW-1:0];

    state_t        state_q, state_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    fmt_t          fmt;
    logic          req, fire, disc_dok, live_dok;

    mem_req_fmt u_fmt (
        .valid_i   (ex_valid),
        .mem_en_i  (ex_mem_en),
        .we_i      (ex_mem_we),
        .size_i    (ex_size),
        .signed_i  (ex_signed),
        .excp_i    (ex_excp_in),
        .vaddr_i   (ex_vaddr),
        .st_data_i (ex_st_data),
        .fmt_o     (fmt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            out_q   <= '0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire && !ME_Allow_in) state_d = ISSUED;
            ISSUED:  if (ME_Allow_in || flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Orphaned responses share the same budget as live ones so response order is preserved
    always_comb begin
        req = resetn & ex_valid & ex_mem_en & ~fmt.ale & ~ex_excp_in & ~flush &
              (state_q == IDLE) & ((out_q + disc_q) < MAX_C);
        fire        = req & sram.data_sram_addr_ok;
        disc_dok    = sram.data_sram_data_ok & (disc_q != '0);
        live_dok    = sram.data_sram_data_ok & (disc_q == '0) & (out_q != '0);
        me_data_ok  = resetn & sram.data_sram_data_ok & (disc_q == '0);
        ex_ready_go = resetn & (~ex_mem_en | fmt.ale | ex_excp_in |
                                (state_q == ISSUED) | fire);
    end

    always_comb begin
        out_d  = out_q;
        disc_d = disc_q;
        if (flush) begin
            out_d  = '0;
            disc_d = out_q + disc_q + CW'(fire) - CW'(disc_dok | live_dok);
        end else begin
            out_d  = out_q + CW'(fire) - CW'(live_dok);
            disc_d = disc_q - CW'(disc_dok);
        end
    end

    assign sram.data_sram_req   = req;
    assign sram.data_sram_wr    = ex_mem_we;
    assign sram.data_sram_size  = ex_size;
    assign sram.data_sram_wstrb = fmt.wstrb;
    assign sram.data_sram_addr  = ex_vaddr;
    assign sram.data_sram_wdata = fmt.wdata;
    assign ex_ale               = fmt.ale;
    assign ex_dest_flag         = fmt.dest_flag;
    assign outstanding          = out_q;
endmodule

// File: tb/tb_ex_mem_req.sv
// tb/tb_ex_mem_req.sv - directed self-checking bench for ex_mem_req
module tb_ex_mem_req;
    import ex_mem_req_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid, ex_mem_en, ex_mem_we, ex_signed, ex_excp_in;
    logic [1:0]  ex_size;
    logic [31:0] ex_vaddr, ex_st_data;
    logic        ME_Allow_in, flush;
    logic        ex_ready_go, ex_ale, me_data_ok;
    logic [4:0]  ex_dest_flag;
    logic [1:0]  outstanding;
    int          errors = 0;
    int          checks = 0;

    ex_mem_req_if sram ();

    ex_mem_req dut (
        .clk          (clk),
        .resetn       (resetn),
        .ex_valid     (ex_valid),
        .ex_mem_en    (ex_mem_en),
        .ex_mem_we    (ex_mem_we),
        .ex_size      (ex_size),
        .ex_signed    (ex_signed),
        .ex_vaddr     (ex_vaddr),
        .ex_st_data   (ex_st_data),
        .ex_excp_in   (ex_excp_in),
        .ME_Allow_in  (ME_Allow_in),
        .flush        (flush),
        .ex_ready_go  (ex_ready_go),
        .ex_ale       (ex_ale),
        .ex_dest_flag (ex_dest_flag),
        .sram         (sram.master),
        .me_data_ok   (me_data_ok),
        .outstanding  (outstanding)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic valid, input logic we, input logic [1:0] size,
                      input logic sgn, input logic [31:0] addr, input logic [31:0] data);
        ex_valid   = valid;
        ex_mem_en  = 1'b1;
        ex_mem_we  = we;
        ex_size    = size;
        ex_signed  = sgn;
        ex_vaddr   = addr;
        ex_st_data = data;
    endtask

    initial begin
        resetn = 1'b0; ex_valid = 0; ex_mem_en = 0; ex_mem_we = 0; ex_signed = 0;
        ex_excp_in = 0; ex_size = 0; ex_vaddr = 0; ex_st_data = 0;
        ME_Allow_in = 0; flush = 0;
        sram.data_sram_addr_ok = 0; sram.data_sram_data_ok = 0;
        #1;
        check_eq("rst_req", sram.data_sram_req, 0);
        check_eq("rst_out", outstanding, 0);
        check_eq("rst_ready", ex_ready_go, 0);
        check_eq("rst_medok", me_data_ok, 0);
        repeat (2) tick();
        resetn = 1'b1; ME_Allow_in = 1'b1;

        // store byte at offset 3, accepted immediately
        op(1, 1, SZ_BYTE, 0, 32'h1003, 32'h0000_00AB);
        sram.data_sram_addr_ok = 1; #1;
        check_eq("stb_req", sram.data_sram_req, 1);
        check_eq("stb_wr", sram.data_sram_wr, 1);
        check_eq("stb_size", sram.data_sram_size, 0);
        check_eq("stb_wstrb", sram.data_sram_wstrb, 4'b1000);
        check_eq("stb_wdata", sram.data_sram_wdata, 32'hABAB_ABAB);
        check_eq("stb_addr", sram.data_sram_addr, 32'h1003);
        check_eq("stb_ready", ex_ready_go, 1);
        check_eq("stb_dflag", ex_dest_flag, 0);
        tick();
        check_eq("stb_out", outstanding, 1);
        check_eq("stb_state", dut.state_q, IDLE);
        ex_valid = 0; sram.data_sram_addr_ok = 0; sram.data_sram_data_ok = 1; #1;
        check_eq("stb_medok", me_data_ok, 1);
        tick();
        sram.data_sram_data_ok = 0;
        check_eq("stb_out0", outstanding, 0);

        // store half at offset 2
        op(1, 1, SZ_HALF, 0, 32'h1002, 32'h1234_5678); #1;
        check_eq("sth_wstrb", sram.data_sram_wstrb, 4'b1100);
        check_eq("sth_wdata", sram.data_sram_wdata, 32'h5678_5678);
        check_eq("sth_ale", ex_ale, 0);

        // misaligned signed half load
        op(1, 0, SZ_HALF, 1, 32'h2001, 0); #1;
        check_eq("ldh_ale", ex_ale, 1);
        check_eq("ldh_req", sram.data_sram_req, 0);
        check_eq("ldh_ready", ex_ready_go, 1);
        tick();
        check_eq("ldh_out", outstanding, 0);

        // misaligned word, then earlier exception suppressing an aligned load
        op(1, 0, SZ_WORD, 0, 32'h2002, 0); #1;
        check_eq("ldw_ale", ex_ale, 1);
        op(1, 0, SZ_WORD, 0, 32'h2000, 0); ex_excp_in = 1; #1;
        check_eq("excp_ale", ex_ale, 0);
        check_eq("excp_req", sram.data_sram_req, 0);
        check_eq("excp_ready", ex_ready_go, 1);
        ex_excp_in = 0;

        // dest_flag codes
        op(0, 0, SZ_BYTE, 1, 32'h0001, 0); #1;
        check_eq("dflag_ldb", ex_dest_flag, 5'b11001);
        op(0, 0, SZ_HALF, 0, 32'h0002, 0); #1;
        check_eq("dflag_ldhu", ex_dest_flag, 5'b00110);
        op(0, 0, SZ_WORD, 1, 32'h0000, 0); #1;
        check_eq("dflag_ldw", ex_dest_flag, 5'b00000);

        // ld.bu with addr_ok delayed three cycles
        op(1, 0, SZ_BYTE, 0, 32'h3002, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("ldbu_req_hold", sram.data_sram_req, 1);
            check_eq("ldbu_stall", ex_ready_go, 0);
            tick();
        end
        check_eq("ldbu_dflag", ex_dest_flag, 5'b01010);
        check_eq("ldbu_wstrb", sram.data_sram_wstrb, 0);
        sram.data_sram_addr_ok = 1; #1;
        check_eq("ldbu_ready", ex_ready_go, 1);
        tick();
        check_eq("ldbu_out", outstanding, 1);
        ex_valid = 0; sram.data_sram_addr_ok = 0;
        tick();
        sram.data_sram_data_ok = 1; #1;
        check_eq("ldbu_medok", me_data_ok, 1);
        tick();
        sram.data_sram_data_ok = 0;
        check_eq("ldbu_out0", outstanding, 0);

        // accepted while ME is stalled -> ISSUED, no reissue
        op(1, 0, SZ_WORD, 0, 32'h4000, 0); ME_Allow_in = 0; sram.data_sram_addr_ok = 1; #1;
        check_eq("iss_req", sram.data_sram_req, 1);
        tick();
        sram.data_sram_addr_ok = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("iss_noreq", sram.data_sram_req, 0);
            check_eq("iss_ready", ex_ready_go, 1);
            check_eq("iss_out", outstanding, 1);
            tick();
        end
        ME_Allow_in = 1;
        tick();
        ex_valid = 0;
        check_eq("iss_idle", dut.state_q, IDLE);
        sram.data_sram_data_ok = 1; #1;
        check_eq("iss_medok", me_data_ok, 1);
        tick();
        sram.data_sram_data_ok = 0;
        check_eq("iss_out0", outstanding, 0);

        // two in flight, flush, orphaned responses swallowed
        op(1, 0, SZ_WORD, 0, 32'h5000, 0); sram.data_sram_addr_ok = 1;
        tick();
        op(1, 0, SZ_WORD, 0, 32'h5004, 0);
        tick();
        check_eq("fl_out2", outstanding, 2);
        op(1, 0, SZ_WORD, 0, 32'h5008, 0); #1;
        check_eq("fl_full_req", sram.data_sram_req, 0);
        check_eq("fl_full_ready", ex_ready_go, 0);
        flush = 1; #1;
        check_eq("fl_noreq", sram.data_sram_req, 0);
        tick();
        flush = 0;
        check_eq("fl_out", outstanding, 0);
        check_eq("fl_disc", dut.disc_q, 2);
        op(1, 0, SZ_WORD, 0, 32'h6000, 0); sram.data_sram_data_ok = 1; #1;
        check_eq("fl_blk_req", sram.data_sram_req, 0);
        check_eq("fl_drop1", me_data_ok, 0);
        tick();
        sram.data_sram_data_ok = 0; #1;
        check_eq("fl_new_req", sram.data_sram_req, 1);
        tick();
        ex_valid = 0; sram.data_sram_addr_ok = 0;
        check_eq("fl_new_out", outstanding, 1);
        sram.data_sram_data_ok = 1; #1;
        check_eq("fl_drop2", me_data_ok, 0);
        tick();
        check_eq("fl_disc0", dut.disc_q, 0);
        check_eq("fl_live_out", outstanding, 1);
        #1;
        check_eq("fl_live_medok", me_data_ok, 1);
        tick();
        sram.data_sram_data_ok = 0;
        check_eq("fl_out0", outstanding, 0);

        // async reset while ISSUED
        op(1, 0, SZ_WORD, 0, 32'h7000, 0); ME_Allow_in = 0; sram.data_sram_addr_ok = 1;
        tick();
        sram.data_sram_addr_ok = 0;
        check_eq("ar_pre_out", outstanding, 1);
        #2 resetn = 0; #1;
        check_eq("ar_out", outstanding, 0);
        check_eq("ar_req", sram.data_sram_req, 0);
        check_eq("ar_state", dut.state_q, IDLE);
        check_eq("ar_ready", ex_ready_go, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
